// File: rtl/uart_rx_oversampled.sv
// UART receiver with ClkTicks-times oversampling driven by the baud timer tick.
// Frame: start bit, DataBits data bits LSB first, optional even parity, one stop bit.
// Received words and their error flags are offered on a valid/ready output register.
//
// Handshake: a word transfers on any clk edge where rd_valid=1 and rd_ready=1.
// While rd_valid=1 and rd_ready=0, rd_data, parity_err and frame_err hold steady.
// A frame that completes while the held word is stalled is dropped and flagged by
// a one-cycle overrun pulse.
module uart_rx_oversampled #(
    parameter int DataBits = 8,
    parameter int ClkTicks = 16,
    parameter int ParityEn = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                rx,
    output logic [DataBits-1:0] rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun,
    output logic                busy
);

    localparam int SW = (ClkTicks > 1) ? $clog2(ClkTicks) : 1;
    localparam int NW = (DataBits > 1) ? $clog2(DataBits) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                rx_meta;
    logic                rx_s;
    logic [SW-1:0]       s;
    logic [NW-1:0]       n;
    logic [DataBits-1:0] shreg;
    logic                par_bit;
    logic                mid_tick;
    logic                end_tick;
    logic                last_bit;
    logic                frame_done;

    // Mid-bit of the start bit and end of a full bit period, both qualified by tick.
    assign mid_tick = tick && (s == SW'(ClkTicks / 2 - 1));
    assign end_tick = tick && (s == SW'(ClkTicks - 1));
    assign last_bit = (n == NW'(DataBits - 1));
    assign busy     = (state != IDLE);

    // Two-flop synchronizer; presets to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; frame_done marks the stop-sample cycle.
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (mid_tick) state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (end_tick && last_bit) state_next = (ParityEn != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (end_tick) state_next = STOP;
            end
            STOP: begin
                if (end_tick) begin
                    frame_done = 1'b1;
                    state_next = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Oversampling counter: cleared on every state change, wraps each bit period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s <= '0;
        end else if (state_next != state) begin
            s <= '0;
        end else if (tick && state != IDLE && state != WAIT_HIGH) begin
            s <= end_tick ? '0 : s + 1'b1;
        end
    end

    // Data shift register, bit index and parity capture at each bit's sample point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n       <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (state == DATA && end_tick) begin
                shreg <= {rx_s, shreg[DataBits-1:1]};
                n     <= last_bit ? '0 : n + 1'b1;
            end
            if (state == PARITY && end_tick) begin
                par_bit <= rx_s;
            end
        end
    end

    // Output register: load on completion if free or draining, else drop and flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!rd_valid || rd_ready) begin
                    rd_data    <= shreg;
                    parity_err <= (ParityEn != 0) ? ((^shreg) ^ par_bit) : 1'b0;
                    frame_err  <= ~rx_s;
                    rd_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Serial-to-parallel UART receiver that recovers frames from an asynchronous line using ClkTicks-times oversampling driven by the shared baud Timer tick. Each frame is one start bit, DataBits data bits sent LSB first, an optional even-parity bit, and one stop bit. The block is the line-side counterpart of the UART transmitter. It delivers each word plus per-word error flags through a valid/ready interface to the receive FIFO.

Parameters:
DataBits, 8, number of data bits per frame
ClkTicks, 16, oversampling ticks per bit; must be even and ≥4
ParityEn, 1, 1 means a frame carries an even-parity bit after the data; 0 means no parity bit

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle baud×ClkTicks strobe from the Timer
rx  input  1  serial line; asynchronous to clk; idles high
rd_data  output  DataBits  received word
rd_valid  output  1  rd_data and the error flags are valid
rd_ready  input  1  consumer accepts the word
parity_err  output  1  parity mismatch for the current word; forced 0 when ParityEn=0
frame_err  output  1  stop bit of the current word sampled low
overrun  output  1  one-cycle pulse when a completed frame is dropped
busy  output  1  state is not IDLE

Behaviour:
- Reset: all state clears immediately, including mid-frame.
  - rd_data=0, rd_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - State goes to IDLE; synchronizer flops preset to 1.
- rx path: passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s.
- Counters:
  - s: 0..ClkTicks-1. Advances only on tick and is cleared on every state change.
  - n: 0..DataBits-1, the data bit index.
- IDLE: when rx_s=0, go to START with s=0. No tick is required for this transition.
- START: on each tick, s increments.
  - At the tick where s=ClkTicks/2-1: if rx_s=0, go to DATA with s=0. If rx_s=1, treat as a glitch and return to IDLE with no output.
  - Each later sample therefore falls at mid-bit.
- DATA: at the tick where s=ClkTicks-1:
  - Shift rx_s into the MSB of the shift register, shifting right, so the word ends LSB-first.
  - Increment n.
  - After bit DataBits-1, go to PARITY if ParityEn=1, else to STOP.
- PARITY: at the tick where s=ClkTicks-1, capture the bit. Mismatch condition: XOR of the data bits and the parity bit equals 1.
- STOP: at the tick where s=ClkTicks-1, sample the stop bit and complete the frame.
  - Stop bit 1: go to IDLE.
  - Stop bit 0: go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from re-triggering reception.
- Frame completion and the output register:
  - Completion happens in the cycle of the stop sample. The output register updates on the next clk edge, so rd_valid rises one cycle after the stop-sample tick.
  - If rd_valid=0, or rd_valid=1 with rd_ready=1 in the same cycle: load rd_data, parity_err and frame_err, and set rd_valid=1.
  - If rd_valid=1 with rd_ready=0: drop the new frame, pulse overrun for 1 cycle, and leave the held word and flags unchanged.
- Handshake:
  - Transfer occurs on a cycle where rd_valid=1 and rd_ready=1. rd_valid then falls unless a new frame completes in that same cycle.
  - rd_data and the flags are stable while rd_valid=1 and rd_ready=0.
- Frames with frame_err or parity_err are still delivered, with the flag set.
- tick=0 stalls all counters. rx edges are still synchronized during a stall.

Test Plan:
- Setup for all cases: DataBits=8, ClkTicks=16, ParityEn=1, tick every 4th clk, rd_ready=1 unless stated.
- Send 0xA5 with parity 0 and stop 1 → exactly one rd_valid pulse with rd_data=0xA5, parity_err=0, frame_err=0.
- rx low for 5 ticks, then high → no rd_valid; busy returns to 0 by the 8th tick.
- Send 0x01 with parity bit 0 → rd_data=0x01, parity_err=1.
- Send 0x3C with stop bit 0, and hold rx low 40 ticks → rd_data=0x3C, frame_err=1. busy stays 1 until rx returns high, and no second frame is received.
- rd_ready=0; send 0x11 then 0x22 → rd_data stays 0x11 and overrun pulses once at the end of the second frame. Raising rd_ready then gives one transfer of 0x11, after which rd_valid=0.
- Assert reset midway through the data bits of 0x55 → all outputs 0 and busy=0. A following frame 0x0F is received correctly.
